// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode definitions for the decode stage.
//   - opcode constants for the base integer ISA
//   - alu_op_t   : 4-bit ALU operation encoding consumed by execute
//   - imm_type_t : immediate format selector for imm_gen
//   - ctrl_t     : control bundle carried in the ID/EX register
//   - dec_t      : full combinational decode result (control + routing info)
//   - decode()   : opcode/funct3/funct7[5] -> dec_t
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_t;

    typedef struct packed {
        alu_op_t    alu_op;
        logic [2:0] funct3;
        logic       alu_src_imm;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        ctrl_t     ctrl;
        imm_type_t imm_type;
        logic      use_rs1;   // rs1 is a real source (hazard check)
        logic      use_rs2;   // rs2 is a real source (hazard check)
        logic      rd_zero;   // format has no destination register
    } dec_t;

    // funct3 -> ALU op for the register and immediate ALU groups.
    // sub_sel picks SUB over ADD, sra_sel picks SRA over SRL.
    function automatic alu_op_t alu_from_funct(input logic [2:0] funct3,
                                               input logic       sub_sel,
                                               input logic       sra_sel);
        alu_op_t op;
        case (funct3)
            3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = sra_sel ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // bit30 is funct7[5] for OP and imm[10] for OP-IMM shifts.
    function automatic dec_t decode(input logic [6:0] opcode,
                                    input logic [2:0] funct3,
                                    input logic       bit30);
        dec_t d;
        d                  = '0;
        d.ctrl.alu_op      = ALU_ADD;
        d.ctrl.funct3      = funct3;
        d.imm_type         = IMM_I;
        d.use_rs1          = 1'b1;
        case (opcode)
            OPC_OP: begin
                // SUB only exists in the register form; SRA exists in both.
                d.ctrl.alu_op    = alu_from_funct(funct3, bit30, bit30);
                d.ctrl.reg_write = 1'b1;
                d.use_rs2        = 1'b1;
            end
            OPC_OP_IMM: begin
                d.ctrl.alu_op      = alu_from_funct(funct3, 1'b0, bit30);
                d.ctrl.alu_src_imm = 1'b1;
                d.ctrl.reg_write   = 1'b1;
            end
            OPC_LOAD: begin
                d.ctrl.mem_read    = 1'b1;
                d.ctrl.alu_src_imm = 1'b1;
                d.ctrl.reg_write   = 1'b1;
            end
            OPC_STORE: begin
                d.ctrl.mem_write   = 1'b1;
                d.ctrl.alu_src_imm = 1'b1;
                d.imm_type         = IMM_S;
                d.use_rs2          = 1'b1;
                d.rd_zero          = 1'b1;
            end
            OPC_BRANCH: begin
                d.ctrl.branch = 1'b1;
                d.ctrl.alu_op = ALU_SUB;
                d.imm_type    = IMM_B;
                d.use_rs2     = 1'b1;
                d.rd_zero     = 1'b1;
            end
            OPC_JAL: begin
                d.ctrl.jump        = 1'b1;
                d.ctrl.reg_write   = 1'b1;
                d.ctrl.alu_src_imm = 1'b1;
                d.imm_type         = IMM_J;
                d.use_rs1          = 1'b0;
            end
            OPC_JALR: begin
                d.ctrl.jump        = 1'b1;
                d.ctrl.reg_write   = 1'b1;
                d.ctrl.alu_src_imm = 1'b1;
            end
            OPC_LUI: begin
                d.ctrl.alu_op      = ALU_PASSB;
                d.ctrl.alu_src_imm = 1'b1;
                d.ctrl.reg_write   = 1'b1;
                d.imm_type         = IMM_U;
                d.use_rs1          = 1'b0;
            end
            OPC_AUIPC: begin
                d.ctrl.alu_src_imm = 1'b1;
                d.ctrl.reg_write   = 1'b1;
                d.imm_type         = IMM_U;
                d.use_rs1          = 1'b0;
            end
            default: begin
                d.ctrl.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate generator.
//   instr    in  [31:7]  instruction word above the opcode field
//   imm_type in  3       format selector (I, S, B, U, J)
//   imm      out XLEN    immediate; I/S/B/J sign-extended from instr[31],
//                        U is instr[31:12]<<12, B/J have bit 0 cleared
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_type_t       imm_type,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        imm32 = '0;
        case (imm_type)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Wider datapaths sign-extend the 32-bit immediate.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode plus the ID/EX pipeline register.
//   clk, reset (async, active low)
//   in_valid/in_instr/in_pc/in_ready   : fetch side handshake
//   reg_a, reg_b                       : register-file read addresses (comb)
//   rf_data_a, rf_data_b               : register-file read data
//   wb_we, wb_reg, wb_data             : writeback port, bypassed into operands
//   flush                              : kill the instruction in decode
//   out_ready/out_valid + out_*        : ID/EX payload towards execute
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_pc,
    output logic            in_ready,
    output logic [4:0]      reg_a,
    output logic [4:0]      reg_b,
    input  logic [XLEN-1:0] rf_data_a,
    input  logic [XLEN-1:0] rf_data_b,
    input  logic            wb_we,
    input  logic [4:0]      wb_reg,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [3:0]      out_alu_op,
    output logic [2:0]      out_funct3,
    output logic            out_alu_src_imm,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_reg_write,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal
);

    // x0 reads as zero; a same-cycle writeback wins over the register file.
    function automatic logic [XLEN-1:0] pick_operand(input logic [4:0]      idx,
                                                     input logic [XLEN-1:0] rf,
                                                     input logic            we,
                                                     input logic [4:0]      wreg,
                                                     input logic [XLEN-1:0] wdata);
        logic [XLEN-1:0] v;
        if (idx == 5'd0)                v = '0;
        else if (we && (wreg == idx))   v = wdata;
        else                            v = rf;
        return v;
    endfunction

    // ---------------- combinational decode ----------------
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    dec_t            dec;
    logic [XLEN-1:0] imm;
    logic            load_use;

    assign rs1   = in_instr[19:15];
    assign rs2   = in_instr[24:20];
    assign reg_a = rs1;
    assign reg_b = rs2;
    assign dec   = decode(in_instr[6:0], in_instr[14:12], in_instr[30]);
    assign rd    = dec.rd_zero ? 5'd0 : in_instr[11:7];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr    (in_instr[31:7]),
        .imm_type (dec.imm_type),
        .imm      (imm)
    );

    // ---------------- ID/EX register ----------------
    logic            valid_q,     valid_d;
    logic [XLEN-1:0] pc_q,        pc_d;
    logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic [4:0]      rs1_q,       rs1_d;
    logic [4:0]      rs2_q,       rs2_d;
    logic [4:0]      rd_q,        rd_d;
    ctrl_t           ctrl_q,      ctrl_d;

    // A load in ID/EX whose result a source of the decoding instruction needs.
    // The loaded value is not available yet, so decode stalls one cycle.
    assign load_use = valid_q && ctrl_q.mem_read && (rd_q != 5'd0) && in_valid &&
                      ((dec.use_rs1 && (rd_q == rs1)) ||
                       (dec.use_rs2 && (rd_q == rs2)));

    // Nothing is accepted while the stage is held in reset.
    assign in_ready = reset && (flush || (out_ready && !load_use));

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;
        if (flush) begin
            // Flush beats backpressure: the killed slot need not drain.
            valid_d = 1'b0;
        end else if (!out_ready) begin
            // hold everything
        end else if (load_use) begin
            valid_d = 1'b0;
        end else begin
            valid_d    = in_valid;
            pc_d       = XLEN'(in_pc);
            rs1_data_d = pick_operand(rs1, rf_data_a, wb_we, wb_reg, wb_data);
            rs2_data_d = pick_operand(rs2, rf_data_b, wb_we, wb_reg, wb_data);
            imm_d      = imm;
            rs1_d      = rs1;
            rs2_d      = rs2;
            rd_d       = rd;
            ctrl_d     = dec.ctrl;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_pc          = pc_q;
    assign out_rs1_data    = rs1_data_q;
    assign out_rs2_data    = rs2_data_q;
    assign out_imm         = imm_q;
    assign out_rs1         = rs1_q;
    assign out_rs2         = rs2_q;
    assign out_rd          = rd_q;
    assign out_alu_op      = ctrl_q.alu_op;
    assign out_funct3      = ctrl_q.funct3;
    assign out_alu_src_imm = ctrl_q.alu_src_imm;
    assign out_mem_read    = ctrl_q.mem_read;
    assign out_mem_write   = ctrl_q.mem_write;
    assign out_reg_write   = ctrl_q.reg_write;
    assign out_branch      = ctrl_q.branch;
    assign out_jump        = ctrl_q.jump;
    assign out_illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage. Hand-computed expected
// ID/EX contents are queued when an instruction is driven and compared when
// execute takes the slot (out_valid & out_ready at the falling edge).
module tb_decode_stage;
    import riscv_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [31:0]     in_instr;
    logic [31:0]     in_pc;
    logic            in_ready;
    logic [4:0]      reg_a;
    logic [4:0]      reg_b;
    logic [XLEN-1:0] rf_data_a;
    logic [XLEN-1:0] rf_data_b;
    logic            wb_we;
    logic [4:0]      wb_reg;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            out_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [3:0]      out_alu_op;
    logic [2:0]      out_funct3;
    logic            out_alu_src_imm;
    logic            out_mem_read;
    logic            out_mem_write;
    logic            out_reg_write;
    logic            out_branch;
    logic            out_jump;
    logic            out_illegal;

    decode_stage #(.XLEN(XLEN)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_instr        (in_instr),
        .in_pc           (in_pc),
        .in_ready        (in_ready),
        .reg_a           (reg_a),
        .reg_b           (reg_b),
        .rf_data_a       (rf_data_a),
        .rf_data_b       (rf_data_b),
        .wb_we           (wb_we),
        .wb_reg          (wb_reg),
        .wb_data         (wb_data),
        .flush           (flush),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_rs1_data    (out_rs1_data),
        .out_rs2_data    (out_rs2_data),
        .out_imm         (out_imm),
        .out_rs1         (out_rs1),
        .out_rs2         (out_rs2),
        .out_rd          (out_rd),
        .out_alu_op      (out_alu_op),
        .out_funct3      (out_funct3),
        .out_alu_src_imm (out_alu_src_imm),
        .out_mem_read    (out_mem_read),
        .out_mem_write   (out_mem_write),
        .out_reg_write   (out_reg_write),
        .out_branch      (out_branch),
        .out_jump        (out_jump),
        .out_illegal     (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [6:0]  flags;    // {alu_src_imm, mem_read, mem_write, reg_write, branch, jump, illegal}
        logic        chk_imm;
        logic        chk_alu;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, rs1d, rs2d, imm,
                                input logic [4:0] rs1, rs2, rd,
                                input logic [3:0] alu, input logic [2:0] f3,
                                input logic [6:0] flags,
                                input logic chk_imm, chk_alu);
        exp_t e;
        e.pc = pc; e.rs1d = rs1d; e.rs2d = rs2d; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.alu = alu; e.f3 = f3;
        e.flags = flags; e.chk_imm = chk_imm; e.chk_alu = chk_alu;
        return e;
    endfunction

    // Scoreboard: execute consumes ID/EX at the edge after a falling edge
    // where out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (mon_en && out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t  e;
                string p;
                e = exp_q.pop_front();
                p = $sformatf("pc%0h", e.pc);
                check({p, "_pc"},       out_pc,              e.pc);
                check({p, "_rs1_data"}, out_rs1_data,        e.rs1d);
                check({p, "_rs2_data"}, out_rs2_data,        e.rs2d);
                check({p, "_rs1"},      32'(out_rs1),        32'(e.rs1));
                check({p, "_rs2"},      32'(out_rs2),        32'(e.rs2));
                check({p, "_rd"},       32'(out_rd),         32'(e.rd));
                check({p, "_funct3"},   32'(out_funct3),     32'(e.f3));
                check({p, "_ctl"},
                      32'({out_mem_read, out_mem_write, out_reg_write,
                           out_branch, out_jump, out_illegal}),
                      32'(e.flags[5:0]));
                if (e.chk_imm) check({p, "_imm"}, out_imm, e.imm);
                if (e.chk_alu) begin
                    check({p, "_alu_op"},  32'(out_alu_op),      32'(e.alu));
                    check({p, "_src_imm"}, 32'(out_alu_src_imm), 32'(e.flags[6]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, pc, rfa, rfb,
                         input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        rf_data_a = rfa;
        rf_data_b = rfb;
        wb_we     = we;
        wb_reg    = wreg;
        wb_data   = wdata;
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
        in_instr = NOP;
        wb_we    = 1'b0;
    endtask

    // Drive one instruction that must be accepted this cycle.
    task automatic send(input string tag, input logic [31:0] instr, pc, rfa, rfb,
                        input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                        input exp_t e);
        drive(instr, pc, rfa, rfb, we, wreg, wdata);
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_reg_a"},    32'(reg_a),    32'(e.rs1));
        check({tag, "_reg_b"},    32'(reg_b),    32'(e.rs2));
        exp_q.push_back(e);
        tick();
        go_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_instr = NOP; in_pc = '0;
        rf_data_a = '0; rf_data_b = '0; wb_we = 1'b0; wb_reg = '0; wb_data = '0;

        #12;
        check("rst_valid",    32'(out_valid),     32'd0);
        check("rst_pc",       out_pc,             32'd0);
        check("rst_in_ready", 32'(in_ready),      32'd0);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);

        // Basic formats; flags = {src_imm, mrd, mwr, rwr, br, jmp, ill}
        send("addi", 32'h00500093, 32'h100, 32'h11, 32'h22, 1'b0, 5'd0, 32'h0,
             mk(32'h100, 32'h0, 32'h22, 32'h5, 5'd0, 5'd5, 5'd1, ALU_ADD, 3'd0, 7'b1001000, 1'b1, 1'b1));
        send("beq", 32'hFE000EE3, 32'h104, 32'h11, 32'h22, 1'b0, 5'd0, 32'h0,
             mk(32'h104, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd0, ALU_SUB, 3'd0, 7'b0000100, 1'b1, 1'b1));
        // ADD x3,x2,x4 with writeback to x2 bypassed
        send("byp", 32'h004101B3, 32'h108, 32'd10, 32'h77, 1'b1, 5'd2, 32'h55,
             mk(32'h108, 32'h55, 32'h77, 32'h0, 5'd2, 5'd4, 5'd3, ALU_ADD, 3'd0, 7'b0001000, 1'b0, 1'b1));
        // ADDI x7,x0,1 with writeback to x0: x0 must still read 0
        send("x0", 32'h00100393, 32'h10C, 32'd9, 32'h33, 1'b1, 5'd0, 32'd7,
             mk(32'h10C, 32'h0, 32'h33, 32'h1, 5'd0, 5'd1, 5'd7, ALU_ADD, 3'd0, 7'b1001000, 1'b1, 1'b1));
        // SUB x8,x9,x10; wb_we=0 so the matching wb_reg is ignored
        send("sub", 32'h40A48433, 32'h110, 32'h90, 32'hA0, 1'b0, 5'd9, 32'hDEAD,
             mk(32'h110, 32'h90, 32'hA0, 32'h0, 5'd9, 5'd10, 5'd8, ALU_SUB, 3'd0, 7'b0001000, 1'b0, 1'b1));
        // SRAI x11,x12,3; bypass on the rs2 field
        send("srai", 32'h40365593, 32'h114, 32'h12, 32'h44, 1'b1, 5'd3, 32'h3333,
             mk(32'h114, 32'h12, 32'h3333, 32'h403, 5'd12, 5'd3, 5'd11, ALU_SRA, 3'd5, 7'b1001000, 1'b1, 1'b1));
        send("lui", 32'hABCDE6B7, 32'h118, 32'hAA, 32'hBB, 1'b0, 5'd0, 32'h0,
             mk(32'h118, 32'hAA, 32'hBB, 32'hABCDE000, 5'd27, 5'd28, 5'd13, ALU_PASSB, 3'd6, 7'b1001000, 1'b1, 1'b1));
        // SW x14,-8(x15)
        send("sw", 32'hFEE7AC23, 32'h11C, 32'h1000, 32'hCAFE, 1'b0, 5'd0, 32'h0,
             mk(32'h11C, 32'h1000, 32'hCAFE, 32'hFFFFFFF8, 5'd15, 5'd14, 5'd0, ALU_ADD, 3'd2, 7'b1010000, 1'b1, 1'b1));
        // JAL x0,-4
        send("jal", 32'hFFDFF06F, 32'h120, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
             mk(32'h120, 32'h1, 32'h2, 32'hFFFFFFFC, 5'd31, 5'd29, 5'd0, ALU_ADD, 3'd7, 7'b0001010, 1'b1, 1'b0));
        // AUIPC x5,1
        send("auipc", 32'h00001297, 32'h124, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0,
             mk(32'h124, 32'h0, 32'h0, 32'h1000, 5'd0, 5'd0, 5'd5, ALU_ADD, 3'd1, 7'b1001000, 1'b1, 1'b1));
        send("illegal", 32'h0000007F, 32'h128, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0,
             mk(32'h128, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, ALU_ADD, 3'd0, 7'b0000001, 1'b0, 1'b0));

        // Load-use: LW x5,0(x2) then ADD x6,x5,x5
        send("lw", 32'h00012283, 32'h12C, 32'h2000, 32'h0, 1'b0, 5'd0, 32'h0,
             mk(32'h12C, 32'h2000, 32'h0, 32'h0, 5'd2, 5'd0, 5'd5, ALU_ADD, 3'd2, 7'b1101000, 1'b1, 1'b1));
        drive(32'h00528333, 32'h130, 32'h5A, 32'h5A, 1'b0, 5'd0, 32'h0);
        #1;
        check("hazard_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("hazard_bubble", 32'(out_valid), 32'd0);
        send("add_dep", 32'h00528333, 32'h130, 32'h5A, 32'h5A, 1'b0, 5'd0, 32'h0,
             mk(32'h130, 32'h5A, 32'h5A, 32'h0, 5'd5, 5'd5, 5'd6, ALU_ADD, 3'd0, 7'b0001000, 1'b0, 1'b1));
        // A load to x0 never creates a hazard
        send("lw_x0", 32'h00012003, 32'h134, 32'h2000, 32'h0, 1'b0, 5'd0, 32'h0,
             mk(32'h134, 32'h2000, 32'h0, 32'h0, 5'd2, 5'd0, 5'd0, ALU_ADD, 3'd2, 7'b1101000, 1'b1, 1'b1));
        send("add_x0", 32'h00000333, 32'h138, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
             mk(32'h138, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd6, ALU_ADD, 3'd0, 7'b0001000, 1'b0, 1'b1));

        // Backpressure: three cycles of out_ready=0 must hold ID/EX
        send("bp_p", 32'h00500093, 32'h200, 32'h0, 32'h22, 1'b0, 5'd0, 32'h0,
             mk(32'h200, 32'h0, 32'h22, 32'h5, 5'd0, 5'd5, 5'd1, ALU_ADD, 3'd0, 7'b1001000, 1'b1, 1'b1));
        out_ready = 1'b0;
        drive(32'h00100393, 32'h204, 32'h0, 32'h33, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_pc",    out_pc,         32'h200);
            check("bp_imm",   out_imm,        32'h5);
        end
        out_ready = 1'b1;
        send("bp_q", 32'h00100393, 32'h204, 32'h0, 32'h33, 1'b0, 5'd0, 32'h0,
             mk(32'h204, 32'h0, 32'h33, 32'h1, 5'd0, 5'd1, 5'd7, ALU_ADD, 3'd0, 7'b1001000, 1'b1, 1'b1));

        // Flush while execute stalls: the slot holding bp_q is killed
        out_ready = 1'b0;
        flush     = 1'b1;
        drive(32'h00500093, 32'h300, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        flush     = 1'b0;
        out_ready = 1'b1;
        go_idle();
        tick();

        // Asynchronous reset in the middle of a live slot
        send("pre_rst", 32'h00500093, 32'h400, 32'h0, 32'h22, 1'b0, 5'd0, 32'h0,
             mk(32'h400, 32'h0, 32'h22, 32'h5, 5'd0, 5'd5, 5'd1, ALU_ADD, 3'd0, 7'b1001000, 1'b1, 1'b1));
        mon_en = 1'b0;
        drive(32'h00100393, 32'h404, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_valid",    32'(out_valid),       32'd0);
        check("mid_rst_pc",       out_pc,               32'd0);
        check("mid_rst_imm",      out_imm,              32'd0);
        check("mid_rst_rd",       32'(out_rd),          32'd0);
        check("mid_rst_rwr",      32'(out_reg_write),   32'd0);
        check("mid_rst_src_imm",  32'(out_alu_src_imm), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready),        32'd0);
        exp_q.delete();
        go_idle();
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        tick();
        send("post_rst", 32'hFE000EE3, 32'h500, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
             mk(32'h500, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd0, ALU_SUB, 3'd0, 7'b0000100, 1'b1, 1'b1));

        // Drain within a bounded number of cycles
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I instruction decode stage and ID/EX pipeline register.
- Accepts a fetched instruction and PC, and drives the register-file read addresses combinationally.
- Bypasses a same-cycle writeback, generates the immediate and control signals, and detects load-use hazards.
- Presents the result to the execute stage through a valid/ready handshake.
- Sits between fetch and execute; the register file is its direct read-side neighbour.

## Interface
Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- in_ready  out  1  stage accepts in_instr this cycle.
- reg_a, reg_b  out  5  register-file read addresses; equal to in_instr[19:15] and in_instr[24:20].
- rf_data_a, rf_data_b  in  XLEN  register-file read data.
- wb_we, wb_reg, wb_data  in  1/5/XLEN  writeback port, also fed to the register file.
- flush  in  1  taken branch or jump resolved in execute; kill the instruction in decode.
- out_ready  in  1  execute can accept.
- out_valid  out  1  ID/EX holds a live instruction.
- out_pc, out_rs1_data, out_rs2_data, out_imm  out  XLEN  registered operands.
- out_rs1, out_rs2, out_rd  out  5  registered register indices.
- out_alu_op  out  4  riscv_pkg ALU op.
- out_funct3  out  3  passes through for branch and memory size.
- out_alu_src_imm, out_mem_read, out_mem_write, out_reg_write, out_branch, out_jump, out_illegal  out  1  control flags.

## Operation
- Opcodes:
  - OP 0110011 and OP-IMM 0010011: ALU.
  - LOAD 0000011: mem_read, ADD.
  - STORE 0100011: mem_write, ADD.
  - BRANCH 1100011: branch, SUB.
  - JAL 1101111 and JALR 1100111: jump, reg_write.
  - LUI 0110111: PASSB.
  - AUIPC 0010111: ADD.
  - Any other opcode: out_illegal=1, with reg_write, mem_read, mem_write, branch and jump all 0.
- ALU op encodings: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
- SUB and SRA are selected by funct7[5], on OP only for SUB; SRAI uses instr[30].
- Immediates:
  - I, S, B and J formats are sign-extended from instr[31].
  - U format is instr[31:12]<<12.
  - B and J immediates have bit 0 = 0.
- Operand select, applied per source:
  - The index is x0: output 0.
  - Otherwise, if wb_we and wb_reg equals the index: output wb_data.
  - Otherwise: output rf_data.
- out_rd is forced to 0 for STORE and BRANCH.
- Load-use hazard:
  - Condition: out_valid & out_mem_read & out_rd!=0 & in_valid, and out_rd matches a source the instruction uses.
  - rs1 is used by every format except LUI, AUIPC and JAL.
  - rs2 is used by OP, STORE and BRANCH.
- Register update at each clock edge, in priority order:
  1. flush: out_valid<=0; the input is discarded.
  2. !out_ready: hold all outputs.
  3. hazard: out_valid<=0 (bubble); the input is not consumed.
  4. Otherwise: capture the decoded input; out_valid<=in_valid.
- in_ready = flush | (out_ready & !hazard).
- Payload outputs may hold stale values while out_valid=0.

## Timing
- reset low: all outputs go to 0 immediately, without waiting for a clock edge; out_valid=0.
- First capture occurs on the first rising edge after reset deasserts.
- reg_a and reg_b are combinational from in_instr in the same cycle; rf_data is sampled on the same edge.
- Latency: an instruction accepted at edge N appears on the outputs after edge N.
- A hazard inserts exactly one bubble cycle. The dependent instruction enters ID/EX on the next edge, and execute forwards from its WB stage.
- flush takes priority even when out_ready=0.
- A wb write to the same register in the same cycle is bypassed; there is no stale read.

## Structure
- riscv_pkg holds:
  - opcode constants;
  - the alu_op_t enum, 4 bits;
  - the imm_type_t enum (I, S, B, U, J);
  - NOP = 32'h00000013.
- Sub-module imm_gen is combinational: instr in, imm_type in, XLEN immediate out.

## Test plan
- ADDI x1,x0,5 (0x00500093), pc 0x100 → next cycle:
  - out_valid=1, out_pc=0x100, out_rd=1, out_imm=5;
  - out_alu_op=ADD, out_alu_src_imm=1, out_reg_write=1.
- BEQ x0,x0,-4 (0xFE000EE3) → out_imm=0xFFFFFFFC, out_branch=1, out_rd=0, out_alu_op=SUB.
- LW x5,0(x2) (0x00012283) then ADD x6,x5,x5 (0x00528333):
  - in_ready=0 for one cycle and a one-cycle out_valid=0 bubble;
  - the ADD appears the following cycle.
- Bypass:
  - x2 read with rf_data_a=10 and wb_we=1, wb_reg=2, wb_data=0x55 → out_rs1_data=0x55.
  - x0 read with wb_reg=0, wb_data=7 → out_rs1_data=0.
- Backpressure and kill:
  - out_ready=0 for 3 cycles: outputs unchanged and in_ready=0.
  - flush=1 with out_ready=0: out_valid=0 next cycle.
  - reset pulled low mid-stream: all outputs 0 before the next edge.
- Opcode 0x7F: out_illegal=1, out_reg_write=0.
